// File: rtl/dict_finder_if.sv
// Bus between the outer-interpreter sequencer / byte memory (master) and the
// dictionary word finder (slave): start handshake, memory read port, results.
interface dict_finder_if #(
  parameter int ASZ      = 17,
  parameter int DSZ      = 8,
  parameter int LEN_BITS = 5
) ();
  logic                  go;
  logic [ASZ-1:0]        ctx;
  logic [ASZ-1:0]        tib;
  logic [ASZ-1:0]        ma;
  logic [DSZ-1:0]        vi;
  logic                  bsy;
  logic                  done;
  logic                  hit;
  logic                  empty;
  logic [ASZ-1:0]        pfa;
  logic [7-LEN_BITS:0]   flags;
  logic [ASZ-1:0]        tend;
  logic [3:0]            st;

  modport master (
    output go, ctx, tib, vi,
    input  ma, bsy, done, hit, empty, pfa, flags, tend, st
  );

  modport slave (
    input  go, ctx, tib, vi,
    output ma, bsy, done, hit, empty, pfa, flags, tend, st
  );
endinterface

// File: rtl/dict_finder.sv
// Dictionary word finder: skips TIB whitespace, measures the token, walks the
// linked dictionary newest-first. Optional macro DICT_FINDER_CASE_FOLD_EN.
module dict_finder #(
  parameter int         ASZ       = 17,
  parameter int         DSZ       = 8,
  parameter int         LFA_BYTES = 2,
  parameter int         LEN_BITS  = 5,
  parameter logic [7:0] DELIM     = 8'h20
) (
  input logic          clk,
  input logic          rst,
  dict_finder_if.slave bus
);
  localparam int LW     = 8 * LFA_BYTES;
  localparam int TLW    = LEN_BITS + 1;
  localparam int LCW    = (LFA_BYTES > 1) ? $clog2(LFA_BYTES) : 1;
  localparam int MAXLEN = (2 ** LEN_BITS) - 1;

  localparam logic [LW-1:0]  NULL_LINK = '1;
  localparam logic [ASZ-1:0] NULL_ADDR = ASZ'(NULL_LINK);
  localparam logic [ASZ-1:0] NAME_OFS  = ASZ'(LFA_BYTES + 1);
  localparam logic [TLW-1:0] TLEN_MAX  = TLW'(MAXLEN);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_SKIP = 4'd1,
    S_SCAN = 4'd2,
    S_LINK = 4'd3,
    S_LEN  = 4'd4,
    S_CMPN = 4'd5,
    S_CMPT = 4'd6,
    S_NEXT = 4'd7,
    S_FIN  = 4'd8
  } state_e;

  function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef DICT_FINDER_CASE_FOLD_EN
    fold = (b >= 8'h61 && b <= 8'h7a) ? (b - 8'h20) : b;
`else
    fold = b;
`endif
  endfunction

  state_e                state_q, state_d;
  logic [ASZ-1:0]        ptr_q, ptr_d;
  logic [ASZ-1:0]        tstart_q, tstart_d;
  logic [TLW-1:0]        tlen_q, tlen_d;
  logic [ASZ-1:0]        entry_q, entry_d;
  logic [LW-1:0]         link_q, link_d;
  logic [LCW-1:0]        lcnt_q, lcnt_d;
  logic [LEN_BITS-1:0]   idx_q, idx_d;
  logic [7:0]            nbyte_q, nbyte_d;
  logic [7-LEN_BITS:0]   nflags_q, nflags_d;
  logic                  hit_q, hit_d;
  logic                  empty_q, empty_d;
  logic [ASZ-1:0]        pfa_q, pfa_d;
  logic [7-LEN_BITS:0]   flags_q, flags_d;
  logic [ASZ-1:0]        tend_q, tend_d;

  logic [7:0]            vb;
  logic [ASZ-1:0]        ptr_inc;
  logic [LEN_BITS-1:0]   idx_inc;

  assign vb      = bus.vi[7:0];
  assign ptr_inc = ptr_q + ASZ'(1);
  assign idx_inc = idx_q + LEN_BITS'(1);

  // Each state drives ma for the byte that the following state consumes.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    tstart_d = tstart_q;
    tlen_d   = tlen_q;
    entry_d  = entry_q;
    link_d   = link_q;
    lcnt_d   = lcnt_q;
    idx_d    = idx_q;
    nbyte_d  = nbyte_q;
    nflags_d = nflags_q;
    hit_d    = hit_q;
    empty_d  = empty_q;
    pfa_d    = pfa_q;
    flags_d  = flags_q;
    tend_d   = tend_q;
    bus.ma   = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          bus.ma  = bus.tib;
          ptr_d   = bus.tib;
          entry_d = bus.ctx;
          hit_d   = 1'b0;
          empty_d = 1'b0;
          pfa_d   = '0;
          flags_d = '0;
          tend_d  = '0;
          state_d = S_SKIP;
        end
      end

      S_SKIP: begin
        bus.ma = ptr_inc;
        if (vb == 8'h00) begin
          empty_d = 1'b1;
          state_d = S_FIN;
        end else if (vb <= DELIM) begin
          ptr_d = ptr_inc;
        end else begin
          tstart_d = ptr_q;
          tlen_d   = TLW'(1);
          ptr_d    = ptr_inc;
          state_d  = S_SCAN;
        end
      end

      S_SCAN: begin
        if (vb > DELIM) begin
          bus.ma = ptr_inc;
          ptr_d  = ptr_inc;
          // Saturate one past the maximum so an overlong token stays detectable.
          if (tlen_q <= TLEN_MAX) tlen_d = tlen_q + TLW'(1);
        end else begin
          tend_d = ptr_q;
          lcnt_d = '0;
          if (tlen_q > TLEN_MAX || entry_q == NULL_ADDR) begin
            state_d = S_FIN;
          end else begin
            bus.ma  = entry_q;
            state_d = S_LINK;
          end
        end
      end

      S_LINK: begin
        link_d[lcnt_q*8 +: 8] = vb;
        bus.ma = entry_q + ASZ'(lcnt_q) + ASZ'(1);
        if (lcnt_q == LCW'(LFA_BYTES - 1)) state_d = S_LEN;
        else                               lcnt_d  = lcnt_q + LCW'(1);
      end

      S_LEN: begin
        nflags_d = vb[7:LEN_BITS];
        if (TLW'(vb[LEN_BITS-1:0]) != tlen_q) begin
          state_d = S_NEXT;
        end else begin
          idx_d   = '0;
          bus.ma  = entry_q + NAME_OFS;
          state_d = S_CMPN;
        end
      end

      S_CMPN: begin
        nbyte_d = fold(vb);
        bus.ma  = tstart_q + ASZ'(idx_q);
        state_d = S_CMPT;
      end

      S_CMPT: begin
        if (fold(vb) != nbyte_q) begin
          state_d = S_NEXT;
        end else if ({1'b0, idx_q} == tlen_q - TLW'(1)) begin
          hit_d   = 1'b1;
          pfa_d   = entry_q + NAME_OFS + ASZ'(tlen_q);
          flags_d = nflags_q;
          state_d = S_FIN;
        end else begin
          idx_d   = idx_inc;
          bus.ma  = entry_q + NAME_OFS + ASZ'(idx_inc);
          state_d = S_CMPN;
        end
      end

      S_NEXT: begin
        if (link_q == NULL_LINK) begin
          state_d = S_FIN;
        end else begin
          entry_d = ASZ'(link_q);
          bus.ma  = ASZ'(link_q);
          lcnt_d  = '0;
          state_d = S_LINK;
        end
      end

      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      tstart_q <= '0;
      tlen_q   <= '0;
      entry_q  <= '0;
      link_q   <= '0;
      lcnt_q   <= '0;
      idx_q    <= '0;
      nbyte_q  <= '0;
      nflags_q <= '0;
      hit_q    <= 1'b0;
      empty_q  <= 1'b0;
      pfa_q    <= '0;
      flags_q  <= '0;
      tend_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      tstart_q <= tstart_d;
      tlen_q   <= tlen_d;
      entry_q  <= entry_d;
      link_q   <= link_d;
      lcnt_q   <= lcnt_d;
      idx_q    <= idx_d;
      nbyte_q  <= nbyte_d;
      nflags_q <= nflags_d;
      hit_q    <= hit_d;
      empty_q  <= empty_d;
      pfa_q    <= pfa_d;
      flags_q  <= flags_d;
      tend_q   <= tend_d;
    end
  end

  assign bus.bsy   = (state_q != S_IDLE) && (state_q != S_FIN);
  assign bus.done  = (state_q == S_FIN);
  assign bus.hit   = hit_q;
  assign bus.empty = empty_q;
  assign bus.pfa   = pfa_q;
  assign bus.flags = flags_q;
  assign bus.tend  = tend_q;
  assign bus.st    = state_q;
endmodule

// File: tb/tb_dict_finder.sv
// Self-checking bench for dict_finder: directed scenarios plus randomized tokens
// scored against a plain-arithmetic dictionary search model.
`timescale 1ns/1ps
module tb_dict_finder;
  localparam int ASZ = 17;
  localparam int M   = 1 << ASZ;

  typedef struct {
    bit hit;
    bit empty;
    int pfa;
    int flags;
    int tend;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] mem [0:M-1];

  always #5 clk = ~clk;

  dict_finder_if #(.ASZ(ASZ), .DSZ(8), .LEN_BITS(5)) bus ();

  dict_finder #(.ASZ(ASZ), .DSZ(8), .LFA_BYTES(2), .LEN_BITS(5), .DELIM(8'h20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Synchronous byte memory: address in cycle N, data in cycle N+1.
  always @(posedge clk) bus.vi <= mem[bus.ma];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rd(input int a);
    return int'(mem[a % M]);
  endfunction

  function automatic int up(input int b);
`ifdef DICT_FINDER_CASE_FOLD_EN
    return (b >= 97 && b <= 122) ? b - 32 : b;
`else
    return b;
`endif
  endfunction

  // Reference: scan token, then search the linked list newest-first.
  function automatic res_t model(input int tib_a, input int ctx_a);
    res_t r;
    int p, ts, tl, e, ln;
    bit same;
    r = '{default: 0};
    p = tib_a;
    while (rd(p) != 0 && rd(p) <= 32) p = (p + 1) % M;
    if (rd(p) == 0) begin
      r.empty = 1;
      return r;
    end
    ts = p;
    tl = 0;
    while (rd(p) > 32 && tl < 1000) begin
      tl++;
      p = (p + 1) % M;
    end
    r.tend = p;
    if (tl > 31) return r;
    e = ctx_a;
    while (e != 'hffff) begin
      ln = rd(e + 2) & 31;
      if (ln == tl) begin
        same = 1;
        for (int k = 0; k < tl; k++)
          if (up(rd(e + 3 + k)) != up(rd(ts + k))) same = 0;
        if (same) begin
          r.hit   = 1;
          r.pfa   = (e + 3 + tl) % M;
          r.flags = rd(e + 2) >> 5;
          return r;
        end
      end
      e = rd(e) | (rd(e + 1) << 8);
    end
    return r;
  endfunction

  task automatic put_entry(input int a, input int link, input int lenb, input string name);
    mem[a]     = 8'(link);
    mem[a + 1] = 8'(link >> 8);
    mem[a + 2] = 8'(lenb);
    for (int k = 0; k < name.len(); k++) mem[a + 3 + k] = name[k];
    mem[a + 3 + name.len()] = 8'hee;
    mem[a + 4 + name.len()] = 8'hee;
  endtask

  task automatic put_str(input int a, input string s, input int term);
    for (int k = 0; k < s.len(); k++) mem[(a + k) % M] = s[k];
    mem[(a + s.len()) % M] = 8'(term);
  endtask

  // One search: check against the model, one done pulse, results held afterwards.
  task automatic run(input string tag, input int tib_a, input int ctx_a, output bit dict_rd);
    res_t e;
    int   cyc;
    int   dones;
    e       = model(tib_a, ctx_a);
    dict_rd = 0;
    dones   = 0;
    cyc     = 0;
    @(negedge clk);
    bus.go  = 1'b1;
    bus.tib = ASZ'(tib_a);
    bus.ctx = ASZ'(ctx_a);
    @(negedge clk);
    bus.go  = 1'b0;
    bus.tib = '0;
    bus.ctx = '0;
    check({tag, ".bsy"}, 32'(bus.bsy), 1);
    check({tag, ".clr"}, {bus.hit, bus.empty, bus.pfa != 0, bus.tend != 0}, 0);
    while (dones == 0 && cyc < 4000) begin
      if (bus.ma >= 17'h10 && bus.ma < 17'h34) dict_rd = 1;
      @(negedge clk);
      cyc++;
      if (bus.done) dones++;
    end
    check({tag, ".done_seen"}, 32'(dones), 1);
    check({tag, ".bsy_at_done"}, 32'(bus.bsy), 0);
    check({tag, ".hit"}, 32'(bus.hit), 32'(e.hit));
    check({tag, ".empty"}, 32'(bus.empty), 32'(e.empty));
    check({tag, ".pfa"}, 32'(bus.pfa), 32'(e.pfa));
    check({tag, ".flags"}, 32'(bus.flags), 32'(e.flags));
    check({tag, ".tend"}, 32'(bus.tend), 32'(e.tend));
    repeat (4) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check({tag, ".done_once"}, 32'(dones), 1);
    check({tag, ".hold"}, {bus.hit, bus.pfa}, {e.hit, 17'(e.pfa)});
  endtask

  initial begin
    bit    drd;
    int    cyc;
    int    base, ctx_r, nlead, sel;
    string words [9] = '{"abcd", "efgh", "ijkl", "mnop", "abc", "abcde", "ijkm", "q", "xyzw"};
    int    ctxs [5] = '{'h2b, 'h22, 'h19, 'h10, 'hffff};
    int    leads [3] = '{32, 9, 1};
    int    terms [3] = '{0, 32, 10};
    string w;

    for (int a = 0; a < M; a++) mem[a] = 8'h00;
    rst     = 1'b1;
    bus.go  = 1'b0;
    bus.tib = '0;
    bus.ctx = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst.st", 32'(bus.st), 0);
    check("rst.ctl", {bus.bsy, bus.done, bus.hit, bus.empty}, 0);
    check("rst.data", 32'(bus.ma | bus.pfa | bus.tend | 17'(bus.flags)), 0);

    put_entry('h10, 'hffff, 'h04, "abcd");
    put_entry('h19, 'h0010, 'h04, "efgh");
    put_entry('h22, 'h0019, 'ha4, "ijkl");
    put_entry('h2b, 'h0022, 'h04, "mnop");

    put_str(0, "  abcd", 0);
    run("abcd", 0, 'h2b, drd);
    check("abcd.k", {bus.hit, bus.pfa, bus.tend, bus.empty}, {1'b1, 17'h17, 17'd6, 1'b0});

    put_str(0, "mnop efgh", 0);
    run("mnop", 0, 'h2b, drd);
    check("mnop.k", {bus.hit, bus.pfa, bus.tend}, {1'b1, 17'h32, 17'd4});
    run("efgh", 5, 'h2b, drd);
    check("efgh.k", {bus.hit, bus.pfa, bus.tend}, {1'b1, 17'h20, 17'd9});

    put_str(0, "abce", 0);
    run("abce", 0, 'h2b, drd);
    check("abce.k", 32'(bus.hit), 0);
    put_str(0, "abc", 0);
    run("abc", 0, 'h2b, drd);
    check("abc.k", 32'(bus.hit), 0);

    put_str(0, "   ", 0);
    run("blank", 0, 'h2b, drd);
    check("blank.k", {bus.empty, bus.hit, drd}, 3'b100);

    put_str('h200, "xxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxx", 32);
    run("long", 'h200, 'h2b, drd);
    check("long.k", {bus.hit, bus.tend, drd}, {1'b0, 17'h220, 1'b0});

    put_str(0, "ABCD", 0);
    run("upper", 0, 'h2b, drd);
`ifdef DICT_FINDER_CASE_FOLD_EN
    check("upper.k", {bus.hit, bus.pfa}, {1'b1, 17'h17});
`else
    check("upper.k", {bus.hit, bus.pfa}, {1'b0, 17'h0});
`endif

    put_str(0, "abcd", 0);
    run("nodict", 0, 'hffff, drd);
    check("nodict.k", {bus.hit, bus.tend}, {1'b0, 17'd4});

    // Token straddles the top of memory.
    mem[M-2] = 8'h20;
    mem[M-1] = "m";
    put_str(0, "nop", 0);
    run("wrap", M - 2, 'h2b, drd);
    check("wrap.k", {bus.hit, bus.pfa, bus.tend}, {1'b1, 17'h32, 17'd3});

    // Abort a search in its first character compare.
    put_str(0, "mnop", 0);
    @(negedge clk);
    bus.go  = 1'b1;
    bus.tib = '0;
    bus.ctx = 17'h2b;
    @(negedge clk);
    bus.go = 1'b0;
    cyc = 0;
    while (bus.ma != 17'h2e && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("abort.reach", 32'(bus.ma), 32'h2e);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.st", 32'(bus.st), 0);
    check("abort.ctl", {bus.bsy, bus.done}, 0);
    cyc = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) cyc++;
    end
    check("abort.nodone", 32'(cyc), 0);
    put_str(0, "ijkl", 0);
    run("ijkl", 0, 'h2b, drd);
    check("ijkl.k", {bus.hit, bus.pfa, bus.flags}, {1'b1, 17'h29, 3'd5});

    for (int it = 0; it < 40; it++) begin
      base  = 'h1000 + $urandom_range(0, 'h1e000);
      ctx_r = ctxs[$urandom_range(0, 4)];
      nlead = $urandom_range(0, 3);
      for (int k = 0; k < nlead; k++) mem[base + k] = 8'(leads[$urandom_range(0, 2)]);
      sel = $urandom_range(0, 10);
      if (sel < 9) begin
        w = words[sel];
      end else if (sel == 9) begin
        w = "";
        for (int k = 0; k < $urandom_range(1, 34); k++) w = {w, string'(8'($urandom_range(97, 122)))};
      end else begin
        w = "";
      end
      for (int k = 0; k < w.len(); k++)
        if ($urandom_range(0, 3) == 0) w[k] = w[k] - 8'd32;
      put_str(base + nlead, w, (w.len() == 0) ? 0 : terms[$urandom_range(0, 2)]);
      mem[base + nlead + w.len() + 1] = 8'h00;
      run($sformatf("rnd%0d", it), base, ctx_r, drd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
